// File: rtl/cci_mpf_rd_arbiter_pkg.sv
// Shared types and helpers for the MPF channel-0 read arbiter.
// Package name: cci_mpf_rd_arb_pkg.
package cci_mpf_rd_arb_pkg;

    // Widest supported client count; rr_pick always scans this many slots.
    localparam int RD_ARB_MAX_CLIENTS = 16;
    localparam int RD_ARB_IDX_W       = 4;

    typedef logic [RD_ARB_IDX_W-1:0] t_client_idx;

    typedef enum logic [1:0] {
        RD_ARB_RUN      = 2'd0,
        RD_ARB_DRAINING = 2'd1,
        RD_ARB_DRAINED  = 2'd2
    } t_rd_arb_state;

    typedef struct packed {
        logic        found;
        t_client_idx index;
    } t_rr_pick;

    // First set bit of valid at or above ptr, wrapping at 16. Callers zero
    // the bits above their client count, so the wrap is equivalent to
    // wrapping at N_CLIENTS.
    function automatic t_rr_pick rr_pick(input logic [RD_ARB_MAX_CLIENTS-1:0] valid,
                                         input t_client_idx ptr);
        t_rr_pick    r;
        t_client_idx idx;
        r = '0;
        for (int i = 0; i < RD_ARB_MAX_CLIENTS; i++) begin
            idx = ptr + t_client_idx'(i);
            if (!r.found && valid[idx]) begin
                r.found = 1'b1;
                r.index = idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cci_mpf_rd_arbiter_if.sv
// Channel-0 side of the read arbiter: request out to c0Tx, responses from c0Rx.
// master = arbiter, slave = platform shim.
interface cci_mpf_rd_arbiter_if #(
    parameter int ADDR_W       = 42,
    parameter int CLIENT_IDX_W = 2
);
    logic                    tx_rd_valid;
    logic [ADDR_W-1:0]       tx_addr;
    logic [CLIENT_IDX_W-1:0] tx_mdata;
    logic                    c0_tx_alm_full;
    logic                    rx_rd_valid;
    logic [CLIENT_IDX_W-1:0] rx_mdata;

    modport master (
        output tx_rd_valid, tx_addr, tx_mdata,
        input  c0_tx_alm_full, rx_rd_valid, rx_mdata
    );

    modport slave (
        input  tx_rd_valid, tx_addr, tx_mdata,
        output c0_tx_alm_full, rx_rd_valid, rx_mdata
    );
endinterface

// File: rtl/cci_mpf_rr_arb.sv
// Parameterized round-robin arbiter. Pointer advances past the winner on
// every grant; grant is combinational and gated by enable.
module cci_mpf_rr_arb
    import cci_mpf_rd_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     valid,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic             grant_any,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0]                  ptr;
    logic [RD_ARB_MAX_CLIENTS-1:0]     valid_ext;
    t_rr_pick                          pick;

    // Pick the winner starting from the pointer.
    always_comb begin
        valid_ext        = '0;
        valid_ext[N-1:0] = valid;
        pick             = rr_pick(valid_ext, t_client_idx'(ptr));
        grant_any        = enable && pick.found;
        grant_idx        = pick.index[IDX_W-1:0];
        grant            = '0;
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    // Move the pointer one past the client just served.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (grant_idx == IDX_W'(N-1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/cci_mpf_rd_arbiter.sv
// Round-robin sharing of the MPF channel-0 read port among N_CLIENTS
// engines, with almost-full and outstanding-credit gating, client tagging
// in mdata, response steering and a drain handshake.
// Optional statistics counters: define CCI_MPF_RD_ARB_STATS_EN.
//
//   state            | meaning
//   RD_ARB_RUN       | normal arbitration
//   RD_ARB_DRAINING  | grants blocked, waiting for in-flight reads to return
//   RD_ARB_DRAINED   | quiesced, drain_done high until drain_req drops
module cci_mpf_rd_arbiter
    import cci_mpf_rd_arb_pkg::*;
#(
    parameter int N_CLIENTS       = 4,
    parameter int CLIENT_IDX_W    = $clog2(N_CLIENTS),
    parameter int ADDR_W          = 42,
    parameter int MAX_OUTSTANDING = 64,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    cci_mpf_rd_arbiter_if.master       c0,
    input  logic [N_CLIENTS-1:0]        req_valid,
    input  logic [N_CLIENTS*ADDR_W-1:0] req_addr,
    output logic [N_CLIENTS-1:0]        req_grant,
    output logic [N_CLIENTS-1:0]        rsp_valid,
    input  logic                       drain_req,
    output logic                       drain_done,
    output logic [CNT_W-1:0]           outstanding
`ifdef CCI_MPF_RD_ARB_STATS_EN
    ,
    output logic [N_CLIENTS*32-1:0]    stat_grants,
    output logic [31:0]                stat_stall_cycles
`endif
);

    t_rd_arb_state           state, state_nxt;
    logic                    can_issue;
    logic                    grant_any;
    logic [CLIENT_IDX_W-1:0] grant_idx;
    logic                    rx_ok;

    // Issue is allowed only while running, with channel room and credit.
    always_comb begin
        can_issue = (state == RD_ARB_RUN) && !c0.c0_tx_alm_full &&
                    (outstanding < CNT_W'(MAX_OUTSTANDING));
    end

    cci_mpf_rr_arb #(
        .N     (N_CLIENTS),
        .IDX_W (CLIENT_IDX_W)
    ) u_rr_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid     (req_valid),
        .enable    (can_issue),
        .grant     (req_grant),
        .grant_any (grant_any),
        .grant_idx (grant_idx)
    );

    // Register the granted request toward c0Tx, tagged with its client.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c0.tx_rd_valid <= 1'b0;
            c0.tx_addr     <= '0;
            c0.tx_mdata    <= '0;
        end else begin
            c0.tx_rd_valid <= grant_any;
            if (grant_any) begin
                c0.tx_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                c0.tx_mdata <= grant_idx;
            end
        end
    end

    // A response with nothing in flight is ignored so the count never wraps.
    always_comb begin
        rx_ok = c0.rx_rd_valid && (outstanding != '0);
    end

    // Track reads in flight: up on grant, down on response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else begin
            case ({grant_any, rx_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Steer each response to the client named by its tag; bad tags dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= '0;
        end else begin
            rsp_valid <= '0;
            if (c0.rx_rd_valid && (32'(c0.rx_mdata) < N_CLIENTS)) begin
                rsp_valid[c0.rx_mdata] <= 1'b1;
            end
        end
    end

    // Drain FSM state register and registered drain_done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RD_ARB_RUN;
            drain_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            drain_done <= (state_nxt == RD_ARB_DRAINED);
        end
    end

    // Drain FSM next state; dropping drain_req always returns to RUN.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RD_ARB_RUN: begin
                if (drain_req) state_nxt = RD_ARB_DRAINING;
            end
            RD_ARB_DRAINING: begin
                if (!drain_req)
                    state_nxt = RD_ARB_RUN;
                else if ((outstanding == '0) && !c0.tx_rd_valid)
                    state_nxt = RD_ARB_DRAINED;
            end
            RD_ARB_DRAINED: begin
                if (!drain_req) state_nxt = RD_ARB_RUN;
            end
            default: state_nxt = RD_ARB_RUN;
        endcase
    end

`ifdef CCI_MPF_RD_ARB_STATS_EN
    // Per-client grant counts and cycles where requests were held off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_grants       <= '0;
            stat_stall_cycles <= '0;
        end else begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                if (req_grant[i]) stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
            end
            if ((state == RD_ARB_RUN) && (|req_valid) && !can_issue)
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

    // Responses must only arrive for reads actually in flight.
    a_rx_with_credit: assert property (@(posedge clk) disable iff (!reset_n)
        c0.rx_rd_valid |-> (outstanding != '0));

    // Response tags must name an existing client.
    a_rx_tag_range: assert property (@(posedge clk) disable iff (!reset_n)
        c0.rx_rd_valid |-> (32'(c0.rx_mdata) < N_CLIENTS));

endmodule

// File: tb/tb_cci_mpf_rd_arbiter.sv
// Randomized bench for cci_mpf_rd_arbiter against a cycle-level reference
// model built from the arbitration, credit and drain rules.
module tb_cci_mpf_rd_arbiter;

    localparam int N    = 4;
    localparam int AW   = 42;
    localparam int MAXO = 64;
    localparam int IW   = 2;
    localparam int CW   = 7;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [N-1:0]        req_valid;
    logic [N*AW-1:0]     req_addr;
    logic [N-1:0]        req_grant;
    logic [N-1:0]        rsp_valid;
    logic                drain_req;
    logic                drain_done;
    logic [CW-1:0]       outstanding;

    always #5 clk = ~clk;

    cci_mpf_rd_arbiter_if #(.ADDR_W(AW), .CLIENT_IDX_W(IW)) c0if ();

    cci_mpf_rd_arbiter #(
        .N_CLIENTS       (N),
        .ADDR_W          (AW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .c0          (c0if.master),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_grant   (req_grant),
        .rsp_valid   (rsp_valid),
        .drain_req   (drain_req),
        .drain_done  (drain_done),
        .outstanding (outstanding)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 run, 1 draining, 2 drained.
    int             m_ptr, m_out, m_mode, m_txm;
    logic           m_txv, m_done;
    logic [AW-1:0]  m_txa;
    logic [N-1:0]   m_rsp;
    int             inflight[$];
    int             gcount[N];
    int             rx_tag;
    logic [AW-1:0]  addr[N];
    logic [N-1:0]   seen_grant;
    logic           seen_tx;

    task automatic model_reset();
        m_ptr = 0; m_out = 0; m_mode = 0; m_txm = 0;
        m_txv = 1'b0; m_done = 1'b0; m_txa = '0; m_rsp = '0;
        inflight.delete();
    endtask

    function automatic int model_pick();
        int idx;
        if (m_mode != 0 || c0if.c0_tx_alm_full || m_out >= MAXO) return -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_in(input logic [N-1:0] v, input logic alm, input bit rx_en, input logic drn);
        int k;
        req_valid = v;
        c0if.c0_tx_alm_full = alm;
        drain_req = drn;
        for (int i = 0; i < N; i++) begin
            addr[i] = AW'({$urandom, $urandom});
            req_addr[i*AW +: AW] = addr[i];
        end
        rx_tag = -1;
        c0if.rx_rd_valid = 1'b0;
        c0if.rx_mdata = '0;
        if (rx_en && inflight.size() > 0) begin
            k = $urandom_range(inflight.size() - 1);
            rx_tag = inflight[k];
            inflight.delete(k);
            c0if.rx_rd_valid = 1'b1;
            c0if.rx_mdata = IW'(rx_tag);
        end
    endtask

    // Called at posedge+1 with inputs set; checks late in the cycle, then
    // advances the model and returns at the next posedge+1.
    task automatic cycle();
        int g, nm;
        logic [N-1:0] eg;
        #3;
        g = model_pick();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        seen_grant = req_grant;
        seen_tx = c0if.tx_rd_valid;
        chk("req_grant", 64'(req_grant), 64'(eg));
        chk("tx_rd_valid", 64'(c0if.tx_rd_valid), 64'(m_txv));
        if (m_txv) begin
            chk("tx_addr", 64'(c0if.tx_addr), 64'(m_txa));
            chk("tx_mdata", 64'(c0if.tx_mdata), 64'(m_txm));
        end
        chk("outstanding", 64'(outstanding), 64'(m_out));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
        chk("drain_done", 64'(drain_done), 64'(m_done));

        nm = m_mode;
        case (m_mode)
            0: if (drain_req) nm = 1;
            1: if (!drain_req) nm = 0; else if (m_out == 0 && !m_txv) nm = 2;
            default: if (!drain_req) nm = 0;
        endcase
        m_mode = nm;
        m_done = (nm == 2);
        m_out = m_out + ((g >= 0) ? 1 : 0) - ((rx_tag >= 0) ? 1 : 0);
        m_rsp = '0;
        if (rx_tag >= 0) m_rsp[rx_tag] = 1'b1;
        m_txv = (g >= 0);
        if (g >= 0) begin
            m_txa = addr[g];
            m_txm = g;
            m_ptr = (g + 1) % N;
            inflight.push_back(g);
            gcount[g]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiesce();
        int n;
        n = 0;
        while ((inflight.size() > 0 || m_txv || m_mode != 0) && n < 300) begin
            set_in('0, 1'b0, 1'b1, 1'b0);
            cycle();
            n++;
        end
        set_in('0, 1'b0, 1'b0, 1'b0);
        cycle();
    endtask

    initial begin
        int cnt_g, cnt_t, tag;
        logic drn;
        reset_n = 1'b0;
        req_valid = '0; req_addr = '0; drain_req = 1'b0;
        c0if.c0_tx_alm_full = 1'b0; c0if.rx_rd_valid = 1'b0; c0if.rx_mdata = '0;
        rx_tag = -1;
        model_reset();
        #12;
        chk("rst_tx_valid", 64'(c0if.tx_rd_valid), 64'd0);
        chk("rst_tx_addr", 64'(c0if.tx_addr), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_drain_done", 64'(drain_done), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // All clients busy, prompt responses: fair share of 100 grants.
        for (int i = 0; i < N; i++) gcount[i] = 0;
        for (int c = 0; c < 100; c++) begin
            set_in('1, 1'b0, 1'b1, 1'b0);
            cycle();
        end
        for (int i = 0; i < N; i++) chk($sformatf("rr_share%0d", i), 64'(gcount[i]), 64'd25);
        quiesce();

        // Client 2 alone, almost-full over cycles 10..14.
        cnt_g = 0; cnt_t = 0;
        for (int c = 0; c < 20; c++) begin
            set_in(4'b0100, (c >= 10 && c < 15), 1'b0, 1'b0);
            cycle();
            if (c >= 10 && c < 15) begin
                if (seen_grant != '0) cnt_g++;
                if (seen_tx) cnt_t++;
            end
            if (c == 15) chk("almfull_resume", 64'(seen_grant), 64'h4);
        end
        chk("almfull_grants", 64'(cnt_g), 64'd0);
        chk("almfull_slack", 64'(cnt_t), 64'd1);
        quiesce();

        // Credit limit with no responses.
        cnt_g = 0;
        for (int c = 0; c < 70; c++) begin
            set_in('1, 1'b0, 1'b0, 1'b0);
            cycle();
            if (seen_grant != '0) cnt_g++;
        end
        chk("credit_grants", 64'(cnt_g), 64'd64);
        chk("credit_full", 64'(outstanding), 64'd64);
        chk("credit_block", 64'(req_grant), 64'd0);
        set_in('0, 1'b0, 1'b1, 1'b0);
        cycle();
        chk("credit_ret", 64'(outstanding), 64'd63);
        set_in('1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("credit_regrant", 64'(outstanding), 64'd64);
        quiesce();

        // Grant and response in the same cycle at 10 outstanding.
        for (int c = 0; c < 10; c++) begin
            set_in('1, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        chk("same_pre", 64'(outstanding), 64'd10);
        set_in('1, 1'b0, 1'b1, 1'b0);
        tag = rx_tag;
        cycle();
        chk("same_cnt", 64'(outstanding), 64'd10);
        chk("same_rsp", 64'(rsp_valid), 64'(1) << tag);
        quiesce();

        // Drain with 5 reads in flight.
        for (int c = 0; c < 5; c++) begin
            set_in('1, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        set_in('0, 1'b0, 1'b0, 1'b1);
        cycle();
        cnt_g = 0;
        for (int c = 0; c < 8; c++) begin
            set_in('1, 1'b0, (c >= 3), 1'b1);
            cycle();
            if (seen_grant != '0) cnt_g++;
        end
        chk("drain_nogrant", 64'(cnt_g), 64'd0);
        chk("drain_empty", 64'(outstanding), 64'd0);
        chk("drain_early", 64'(drain_done), 64'd0);
        set_in('1, 1'b0, 1'b0, 1'b1);
        cycle();
        chk("drain_done_up", 64'(drain_done), 64'd1);
        set_in('1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("drain_done_dn", 64'(drain_done), 64'd0);
        set_in('1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("drain_resume", 64'(seen_grant != '0), 64'd1);
        quiesce();

        // Random traffic, backpressure and drain requests.
        drn = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(19) == 0) drn = !drn;
            set_in(N'($urandom), ($urandom_range(4) == 0), ($urandom_range(1) == 1), drn);
            cycle();
        end
        quiesce();

        // Asynchronous reset mid-stream with 7 in flight.
        for (int c = 0; c < 7; c++) begin
            set_in('1, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        chk("rst_pre", 64'(outstanding), 64'd7);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_tx_valid", 64'(c0if.tx_rd_valid), 64'd0);
        chk("arst_tx_mdata", 64'(c0if.tx_mdata), 64'd0);
        chk("arst_outstanding", 64'(outstanding), 64'd0);
        chk("arst_rsp", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        set_in('1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("arst_ptr0", 64'(seen_grant), 64'h1);
        quiesce();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

endmodule
